// File: rtl/shared_resource_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : shared_resource_scheduler
// Purpose  : Round-robin scheduler sharing one pipelined resource between
//            NUM_REQ requesting pipelines. It grants at most one issue per
//            cycle, bounds monopolisation with a hold counter, tracks
//            in-flight operations through the fixed resource latency and
//            returns each result strobe to its originator. A pipeline flush
//            cancels that requester's pending request and in-flight results.
// Ports    : clk         - rising-edge clock
//            reset       - asynchronous active-low reset
//            req         - per-pipeline issue request
//            flush       - per-pipeline flush
//            grant       - one-hot (or zero) issue grant, same cycle as req
//            stall       - req & ~grant
//            issue_valid - valid into the shared resource
//            issue_id    - index of granted requester (0 when none)
//            rsp_valid   - one-hot result strobe, LAT cycles after issue
//            busy        - at least one operation in flight
//            hold_cnt    - consecutive grants of the current owner
// Revision : 1.0 - initial release
// ============================================================================
module shared_resource_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int LAT      = 3,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  // Derived width of hold_cnt; leave at its default.
  parameter int HC_W     = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] flush,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] stall,
  output logic               issue_valid,
  output logic [ID_W-1:0]    issue_id,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               busy,
  output logic [HC_W-1:0]    hold_cnt
);

  localparam logic [HC_W-1:0] c_hold_max = HC_W'(MAX_HOLD);
  localparam logic [ID_W-1:0] c_last_rst = ID_W'(NUM_REQ - 1);

  // Arbitration state
  logic [ID_W-1:0] last_q, last_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            owner_valid_q, owner_valid_d;

  // In-flight tracking: stage 0 holds the most recent issue
  logic [LAT-1:0]           pv_q, pv_d;
  logic [LAT-1:0][ID_W-1:0] pid_q, pid_d;

  logic [NUM_REQ-1:0] w_ereq;
  logic [NUM_REQ-1:0] w_others;
  logic               w_keep;
  logic               w_found;
  logic [ID_W-1:0]    w_gidx;
  logic [ID_W-1:0]    w_cand;

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_ereq   = req & ~flush;
    w_others = w_ereq & ~(NUM_REQ'(1) << last_q);
    // The owner keeps the resource until it has used its hold budget, but
    // a lone requester is never forced to give it up.
    w_keep   = owner_valid_q && w_ereq[last_q] &&
               ((hold_cnt_q < c_hold_max) || (w_others == '0));
    w_found  = 1'b0;
    w_gidx   = '0;
    w_cand   = '0;
    if (w_keep) begin
      w_found = 1'b1;
      w_gidx  = last_q;
    end else begin
      // Rotating search starting just after the last granted index; k reaches
      // NUM_REQ so the last owner itself is considered last.
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_cand = ID_W'((int'(last_q) + k) % NUM_REQ);
        if (!w_found && w_ereq[w_cand]) begin
          w_found = 1'b1;
          w_gidx  = w_cand;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all forced low while reset is asserted)
  // --------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    issue_id  = '0;
    rsp_valid = '0;
    if (reset && w_found) begin
      grant[w_gidx] = 1'b1;
      issue_id      = w_gidx;
    end
    issue_valid = |grant;
    stall       = reset ? (req & ~grant) : '0;
    // A flush in the exit cycle still cancels the strobe.
    if (reset && pv_q[LAT-1] && !flush[pid_q[LAT-1]]) begin
      rsp_valid[pid_q[LAT-1]] = 1'b1;
    end
    busy = reset && (|pv_q);
  end

  assign hold_cnt = hold_cnt_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    last_d        = last_q;
    hold_cnt_d    = hold_cnt_q;
    owner_valid_d = owner_valid_q;
    if (w_found) begin
      if (owner_valid_q && (w_gidx == last_q)) begin
        if (hold_cnt_q < c_hold_max) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end else begin
        last_d        = w_gidx;
        hold_cnt_d    = HC_W'(1);
        owner_valid_d = 1'b1;
      end
    end else begin
      hold_cnt_d    = '0;
      owner_valid_d = 1'b0;
    end
  end

  always_comb begin
    pv_d     = '0;
    pid_d    = '0;
    pv_d[0]  = issue_valid;
    pid_d[0] = issue_id;
    // Entries belonging to a flushed requester are dropped as they advance.
    for (int s = 1; s < LAT; s++) begin
      pv_d[s]  = pv_q[s-1] && !flush[pid_q[s-1]];
      pid_d[s] = pid_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q        <= c_last_rst;
      hold_cnt_q    <= '0;
      owner_valid_q <= 1'b0;
      pv_q          <= '0;
      pid_q         <= '0;
    end else begin
      last_q        <= last_d;
      hold_cnt_q    <= hold_cnt_d;
      owner_valid_q <= owner_valid_d;
      pv_q          <= pv_d;
      pid_q         <= pid_d;
    end
  end

endmodule
`default_nettype wire
